coax_rx_buffer: RTL and testbench

- Downstream consumer of the coax receiver.
- Accepts each 10-bit word the receiver presents on its data/data_available/data_read handshake and tags the final word of every frame using the receiver's active output.
- Queues the tagged words in a show-ahead FIFO for the host-side interface.
- Decouples coax line timing from host read latency and flags overflow.

---
 rtl/coax_rx_buffer.sv | 175 +++++++++++++++++
 tb/tb_coax_rx_buffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/coax_rx_buffer.sv
// rtl/coax_rx_buffer.sv - Coax receiver word stager and show-ahead frame FIFO
// Optional feature macro: COAX_RX_BUFFER_FRAME_COUNT_EN (frame_ready from a queued-frame counter)
module coax_rx_buffer #(
  parameter int DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_active,
  input  logic [9:0]            rx_data,
  input  logic                  rx_data_available,
  output logic                  rx_data_read,
  input  logic                  read,
  output logic [9:0]            data,
  output logic                  last,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_BITS:0]   count,
  output logic                  overflow,
  input  logic                  clear_overflow,
  output logic                  frame_ready
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  // receiver-side staging state
  logic                  r_active_d;
  logic [9:0]            r_stage_word;
  logic                  r_stage_valid;
  logic                  r_end_pending;

  // FIFO state: each entry is {last, word}
  logic [10:0]           r_mem [DEPTH];
  logic [DEPTH_BITS-1:0] r_wr_ptr;
  logic [DEPTH_BITS-1:0] r_rd_ptr;
  logic [DEPTH_BITS:0]   r_count;
  logic                  r_overflow;

  logic                  w_capture;
  logic                  w_end_edge;
  logic                  w_push;
  logic                  w_push_last;
  logic [9:0]            w_push_word;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_do_pop;
  logic                  w_do_push;
  logic                  w_drop;
  logic [10:0]           w_head;

  // The receiver drops data_available on the edge it sees data_read, so a
  // word is taken exactly once; we never stall it.
  assign rx_data_read = rx_data_available & reset_n;
  assign w_capture    = rx_data_available;
  assign w_end_edge   = r_active_d & ~rx_active;

  // Choose the single word (if any) that leaves the staging register this cycle
  always_comb begin
    w_push      = 1'b0;
    w_push_last = 1'b0;
    w_push_word = r_stage_word;
    if (r_end_pending) begin
      // the word captured alongside the falling edge closes its frame now
      w_push      = 1'b1;
      w_push_last = 1'b1;
    end else if (w_capture) begin
      // a newer word exists, so the staged one cannot be the last
      w_push      = r_stage_valid;
    end else if (w_end_edge && r_stage_valid) begin
      w_push      = 1'b1;
      w_push_last = 1'b1;
    end
  end

  // Track rx_active and hold the newest word until its last-ness is known
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active_d    <= 1'b0;
      r_stage_word  <= '0;
      r_stage_valid <= 1'b0;
      r_end_pending <= 1'b0;
    end else begin
      r_active_d    <= rx_active;
      r_end_pending <= w_capture & w_end_edge;
      if (w_capture) begin
        r_stage_word  <= rx_data;
        r_stage_valid <= 1'b1;
      end else if (w_push_last) begin
        r_stage_valid <= 1'b0;
      end
    end
  end

  // count never exceeds DEPTH, so its MSB alone marks the full state
  assign w_empty   = (r_count == '0);
  assign w_full    = r_count[DEPTH_BITS];
  assign w_do_pop  = read & ~w_empty;
  assign w_do_push = w_push & (~w_full | w_do_pop);
  assign w_drop    = w_push & w_full & ~w_do_pop;

  // Show-ahead head; storage is not reset, so mask it while empty
  assign w_head = r_mem[r_rd_ptr];
  assign data   = w_empty ? 10'd0 : w_head[9:0];
  assign last   = ~w_empty & w_head[10];
  assign empty  = w_empty;
  assign full   = w_full;
  assign count  = r_count;

  // Write storage on every accepted push
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= {w_push_last, w_push_word};
    end
  end

  // Advance pointers and occupancy; a dropped word leaves them untouched
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_BITS'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_BITS'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (DEPTH_BITS + 1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_BITS + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow; a fresh drop outranks a clear in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;

`ifdef COAX_RX_BUFFER_FRAME_COUNT_EN
  logic [DEPTH_BITS:0] r_frames;
  logic                w_frame_in;
  logic                w_frame_out;

  assign w_frame_in  = w_do_push & w_push_last;
  assign w_frame_out = w_do_pop & w_head[10];

  // Count complete frames held in the FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frames <= '0;
    end else begin
      case ({w_frame_in, w_frame_out})
        2'b10:   r_frames <= r_frames + (DEPTH_BITS + 1)'(1);
        2'b01:   r_frames <= r_frames - (DEPTH_BITS + 1)'(1);
        default: r_frames <= r_frames;
      endcase
    end
  end

  assign frame_ready = (r_frames != '0);
`else
  assign frame_ready = 1'b0;
`endif

endmodule

// File: tb/tb_coax_rx_buffer.sv
// tb/tb_coax_rx_buffer.sv - randomized self-checking bench for coax_rx_buffer
module tb_coax_rx_buffer;

  localparam int DEPTH_BITS = 4;
  localparam int DEPTH      = 1 << DEPTH_BITS;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                rx_active = 1'b0;
  logic [9:0]          rx_data = '0;
  logic                rx_data_available = 1'b0;
  logic                rx_data_read;
  logic                read = 1'b0;
  logic [9:0]          data;
  logic                last;
  logic                empty;
  logic                full;
  logic [DEPTH_BITS:0] count;
  logic                overflow;
  logic                clear_overflow = 1'b0;
  logic                frame_ready;

  coax_rx_buffer #(.DEPTH_BITS(DEPTH_BITS)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .rx_active         (rx_active),
    .rx_data           (rx_data),
    .rx_data_available (rx_data_available),
    .rx_data_read      (rx_data_read),
    .read              (read),
    .data              (data),
    .last              (last),
    .empty             (empty),
    .full              (full),
    .count             (count),
    .overflow          (overflow),
    .clear_overflow    (clear_overflow),
    .frame_ready       (frame_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference: queued entries {last, word}, plus the not-yet-classified word
  logic [10:0] mq[$];
  bit          m_held_v;
  logic [9:0]  m_held_w;
  bit          m_close;
  bit          m_prev_act;
  bit          m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_frame_ready();
`ifdef COAX_RX_BUFFER_FRAME_COUNT_EN
    foreach (mq[i]) if (mq[i][10]) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_held_v   = 1'b0;
    m_held_w   = '0;
    m_close    = 1'b0;
    m_prev_act = 1'b0;
    m_ovf      = 1'b0;
  endtask

  task automatic model_edge(input bit act, input bit av, input logic [9:0] w,
                            input bit rd, input bit clr);
    bit          end_edge;
    bit          push;
    bit          popping;
    bit          drop;
    logic [10:0] pe;
    end_edge = m_prev_act && !act;
    push     = 1'b0;
    drop     = 1'b0;
    pe       = '0;
    if (m_close) begin
      push = 1'b1; pe = {1'b1, m_held_w}; m_held_v = 1'b0; m_close = 1'b0;
      if (av) begin m_held_w = w; m_held_v = 1'b1; m_close = end_edge; end
    end else if (av) begin
      if (m_held_v) begin push = 1'b1; pe = {1'b0, m_held_w}; end
      m_held_w = w; m_held_v = 1'b1; m_close = end_edge;
    end else if (end_edge && m_held_v) begin
      push = 1'b1; pe = {1'b1, m_held_w}; m_held_v = 1'b0;
    end
    popping = rd && (mq.size() > 0);
    if (push && mq.size() == DEPTH && !popping) drop = 1'b1;
    if (popping) void'(mq.pop_front());
    if (push && !drop) mq.push_back(pe);
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_prev_act = act;
  endtask

  task automatic verify();
    check("empty", empty, mq.size() == 0);
    check("full", full, mq.size() == DEPTH);
    check("count", count, mq.size());
    check("overflow", overflow, m_ovf);
    check("frame_ready", frame_ready, m_frame_ready());
    if (mq.size() > 0) begin
      check("head_data", data, mq[0][9:0]);
      check("head_last", last, mq[0][10]);
    end
  endtask

  // one clock: drive at the falling edge, model at the rising edge, compare at the next falling edge
  task automatic step(input bit act, input bit av, input logic [9:0] w,
                      input bit rd, input bit clr);
    rx_active = act; rx_data_available = av; rx_data = w;
    read = rd; clear_overflow = clr;
    #1;
    check("rx_data_read", rx_data_read, av);
    @(posedge clk);
    model_edge(act, av, w, rd, clr);
    @(negedge clk);
    verify();
  endtask

  logic [9:0] words[17];

  initial begin
    model_reset();
    rx_data_available = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_data", data, 0);
    check("rst_last", last, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_ready", frame_ready, 0);
    check("rst_rx_data_read", rx_data_read, 0);
    rx_data_available = 1'b0;
    reset_n = 1'b1;

    // single three-word frame
    step(1, 0, 0, 0, 0);
    step(1, 1, 10'h155, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 10'h2AA, 0, 0);
    step(1, 1, 10'h001, 0, 0);
    step(0, 0, 0, 0, 0);
    check("t1_count", count, 3);
    check("t1_head0", data, 10'h155);
    step(0, 0, 0, 1, 0);
    check("t1_head1", {last, data}, {1'b0, 10'h2AA});
    step(0, 0, 0, 1, 0);
    check("t1_head2", {last, data}, {1'b1, 10'h001});
    step(0, 0, 0, 1, 0);
    check("t1_drained", empty, 1);

    // active pulse with no word
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("t2_empty", empty, 1);

    // word arriving on the falling edge of rx_active
    step(1, 1, 10'h100, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 10'h3FF, 0, 0);
    check("t3_first", {count, last, data}, {5'd1, 1'b0, 10'h100});
    step(0, 0, 0, 0, 0);
    check("t3_count", count, 2);
    step(0, 0, 0, 1, 0);
    check("t3_second", {last, data}, {1'b1, 10'h3FF});
    step(0, 0, 0, 1, 0);

    // 17 words, no reads: the last one is dropped
    for (int i = 0; i < 17; i++) begin
      words[i] = 10'((i * 37 + 5) & 10'h3FF);
      step(1, 1, words[i], 0, 0);
    end
    step(0, 0, 0, 0, 0);
    check("t4_count", count, 16);
    check("t4_overflow", overflow, 1);
    for (int i = 0; i < 16; i++) begin
      check("t4_order", data, words[i]);
      step(0, 0, 0, 1, 0);
    end
    check("t4_empty", empty, 1);
    step(0, 0, 0, 0, 1);
    check("t4_cleared", overflow, 0);

    // full FIFO with push and pop together
    for (int i = 0; i < 17; i++) begin
      words[i] = 10'((i * 91 + 3) & 10'h3FF);
      step(1, 1, words[i], 0, 0);
    end
    step(0, 0, 0, 1, 0);
    check("t5_count", count, 16);
    check("t5_overflow", overflow, 0);
    for (int i = 0; i < 16; i++) begin
      check("t5_order", data, (i < 15) ? words[i + 1] : words[16]);
      step(0, 0, 0, 1, 0);
    end

    // reset mid-frame: 2 queued, 1 staged
    step(1, 1, 10'h011, 0, 0);
    step(1, 1, 10'h022, 0, 0);
    step(1, 1, 10'h033, 0, 0);
    check("t6_pre_count", count, 2);
    rx_active = 1'b0; rx_data_available = 1'b1; reset_n = 1'b0;
    #1;
    check("t6_rst_empty", empty, 1);
    check("t6_rst_count", count, 0);
    check("t6_rst_read", rx_data_read, 0);
    model_reset();
    rx_data_available = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 1, 10'h0AB, 0, 0);
    step(1, 1, 10'h0CD, 0, 0);
    step(0, 0, 0, 0, 0);
    check("t6_head", {count, last, data}, {5'd2, 1'b0, 10'h0AB});
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // randomized frames against the reference model
    for (int f = 0; f < 250; f++) begin
      int len;
      int rp;
      len = $urandom_range(1, 20);
      case ($urandom_range(0, 2))
        0: rp = 10;
        1: rp = 50;
        default: rp = 90;
      endcase
      for (int c = 0; c < len; c++)
        step(1, $urandom_range(0, 1), 10'($urandom), $urandom_range(0, 99) < rp,
             $urandom_range(0, 19) == 0);
      step(0, $urandom_range(0, 2) == 0, 10'($urandom), $urandom_range(0, 99) < rp,
           $urandom_range(0, 19) == 0);
      for (int g = $urandom_range(1, 3); g > 0; g--)
        step(0, 0, 0, $urandom_range(0, 99) < rp, $urandom_range(0, 19) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
